toy_intr_sched: RTL and testbench
=================================

Name: toy_intr_sched

Overview:
Interrupt scheduler between the external-interrupt edge-capture stage and the core's trap/commit logic. It latches the single-cycle edge pulses from the capture stage into pending bits and applies per-source and global enables. It arbitrates by fixed priority and presents one request at a time to the core over a valid/ready handshake. It then holds off further requests until the core signals trap-entry complete with intr_clr.

Parameters:
- NSRC, 7, number of sources. Fixed bit order: 6 debug, 5 MEI, 4 MSI, 3 MTI, 2 SEI, 1 SSI, 0 STI.
- TIMEOUT_CYCLES, 1024, watchdog limit in WAIT_CLR. Used only with the optional feature.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, synchronous, active-high
- intr_debug_sync  in  1  debug halt edge pulse
- intr_meip_sync  in  1  M external edge pulse
- intr_msip_sync  in  1  M software edge pulse
- intr_mtip_sync  in  1  M timer edge pulse
- intr_seip_sync  in  1  S external edge pulse
- intr_ssip_sync  in  1  S software edge pulse
- intr_stip_sync  in  1  S timer edge pulse
- src_en  in  6  per-source enable, bits [5:0] = MEI..STI (mie/sie image)
- m_glb_en  in  1  M-level global enable (mstatus.MIE)
- s_glb_en  in  1  S-level global enable (mstatus.SIE)
- intr_vld  out  1  request to core
- intr_op  out  4  cause code of request
- intr_rdy  in  1  core accepts request
- intr_clr  in  1  core finished trap entry; scheduler rearms
- intr_pending  out  7  pending bits, same order as NSRC
- intr_busy  out  1  high in REQ or WAIT_CLR
- intr_timeout  out  1  watchdog pulse (optional feature only, else tied 0)

Behaviour:
- Reset: all pending bits 0; state IDLE; intr_vld, intr_op, intr_busy, intr_timeout all 0.
- Pending set: a sync pulse in cycle N sets its pending bit at N+1. A pulse on an already-set bit merges; no counting.
- Pending clear: only the granted bit clears, on the cycle where intr_vld && intr_rdy. A new pulse on that same bit in the same cycle wins, so the bit stays 1.
- Eligibility:
  - debug: pending only, not maskable.
  - MEI/MSI/MTI: pending & src_en & m_glb_en.
  - SEI/SSI/STI: pending & src_en & s_glb_en.
  - Disabled sources keep their pending bits.
- Priority: debug > MEI > MSI > MTI > SEI > SSI > STI.
- intr_op encoding: debug 15, MEI 11, MSI 3, MTI 7, SEI 9, SSI 1, STI 5.
- FSM states:
  - IDLE: if any source is eligible, register the winner's index and code; next state REQ.
  - REQ: intr_vld=1. intr_op and the grant index stay stable until handshake. No preemption, even by debug. No withdrawal if enables drop. On intr_vld && intr_rdy, clear the granted pending bit; next state WAIT_CLR.
  - WAIT_CLR: intr_vld=0. On intr_clr, next state IDLE. intr_clr in IDLE or REQ is ignored.
- Latency: pulse at N, idle scheduler, all enables high → intr_vld=1 at N+2.
- Back-to-back: intr_clr at M with another source eligible → IDLE at M+1, intr_vld=1 at M+2. Minimum one IDLE cycle between grants.
- intr_busy = (state != IDLE).
- intr_pending is the registered pending vector.
- rst asserted in any state: return to IDLE and clear all pending bits on the next edge, regardless of other inputs.

Optional Feature:
- Macro: TOY_INTR_SCHED_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_CLR; it resets to 0 on entry to WAIT_CLR.
  - When it reaches TIMEOUT_CYCLES-1 without intr_clr: state goes to IDLE and intr_timeout pulses for 1 cycle.
  - intr_clr on that same cycle takes precedence; no timeout pulse.
- Undefined: no counter; intr_timeout tied 0; WAIT_CLR exits only on intr_clr.

Test Plan:
- Single MEI: src_en=6'h3F, m_glb_en=1, pulse intr_meip_sync at cycle 10, intr_rdy=1 → intr_vld=1 with intr_op=11 at cycle 12, pending[5] cleared at 13; intr_clr at 15 → IDLE at 16.
- Simultaneous pulses: debug, MTI and SSI at the same cycle, all enabled; each grant handshaked, then intr_clr → grants in order op=15, 7, 1, each separated by ≥1 IDLE cycle.
- Masking: SEI pulse with s_glb_en=0 → no intr_vld, pending[2]=1 held; raise s_glb_en → intr_vld with op=9 two cycles later.
- Stability: intr_rdy=0 for 5 cycles holding an MSI request (op=3), MEI pulse mid-hold → op stays 3 until handshake; MEI (op=11) is granted after intr_clr.
- Set/clear collision: re-pulse MTI in the handshake cycle of the MTI grant → pending[3] remains 1; second op=7 request follows intr_clr.
- Reset and timeout: assert rst in REQ → next cycle intr_vld=0 and pending=0. With TOY_INTR_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, withhold intr_clr → intr_timeout pulses on the 8th WAIT_CLR cycle and the state returns to IDLE.

Source files
------------

// File: rtl/toy_intr_sched_if.sv
// rtl/toy_intr_sched_if.sv - core-side request/trap handshake bundle for toy_intr_sched
// The scheduler owns the request and status lines; the core owns rdy/clr.
interface toy_intr_sched_if #(
  parameter int NSRC = 7
);
  logic            intr_vld;
  logic [3:0]      intr_op;
  logic            intr_rdy;
  logic            intr_clr;
  logic [NSRC-1:0] intr_pending;
  logic            intr_busy;
  logic            intr_timeout;

  modport master (
    output intr_vld, intr_op, intr_pending, intr_busy, intr_timeout,
    input  intr_rdy, intr_clr
  );

  modport slave (
    input  intr_vld, intr_op, intr_pending, intr_busy, intr_timeout,
    output intr_rdy, intr_clr
  );
endinterface

// File: rtl/toy_intr_sched.sv
// rtl/toy_intr_sched.sv - fixed-priority interrupt scheduler with valid/ready request and clr rearm
// Optional WAIT_CLR watchdog enabled by defining TOY_INTR_SCHED_TIMEOUT_EN.
module toy_intr_sched #(
  parameter int NSRC           = 7,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             intr_debug_sync,
  input  logic             intr_meip_sync,
  input  logic             intr_msip_sync,
  input  logic             intr_mtip_sync,
  input  logic             intr_seip_sync,
  input  logic             intr_ssip_sync,
  input  logic             intr_stip_sync,
  input  logic [5:0]       src_en,
  input  logic             m_glb_en,
  input  logic             s_glb_en,
  toy_intr_sched_if.master bus
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REQ      = 2'd1;
  localparam logic [1:0] ST_WAIT_CLR = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NSRC-1:0] pend_q, pend_d;
  logic [NSRC-1:0] pulse, elig, clr_mask;
  logic [2:0]      gnt_q, gnt_d, win_idx;
  logic [3:0]      op_q, op_d, win_op;
  logic            win_any;
  logic            hs;
  logic            timeout;

  assign pulse = {intr_debug_sync, intr_meip_sync, intr_msip_sync, intr_mtip_sync,
                  intr_seip_sync, intr_ssip_sync, intr_stip_sync};

  // Debug is never masked; masked sources keep their pending bits.
  assign elig = {pend_q[6],
                 pend_q[5:3] & src_en[5:3] & {3{m_glb_en}},
                 pend_q[2:0] & src_en[2:0] & {3{s_glb_en}}};

  always_comb begin
    win_any = 1'b1;
    win_idx = 3'd0;
    win_op  = 4'd0;
    if      (elig[6]) begin win_idx = 3'd6; win_op = 4'd15; end
    else if (elig[5]) begin win_idx = 3'd5; win_op = 4'd11; end
    else if (elig[4]) begin win_idx = 3'd4; win_op = 4'd3;  end
    else if (elig[3]) begin win_idx = 3'd3; win_op = 4'd7;  end
    else if (elig[2]) begin win_idx = 3'd2; win_op = 4'd9;  end
    else if (elig[1]) begin win_idx = 3'd1; win_op = 4'd1;  end
    else if (elig[0]) begin win_idx = 3'd0; win_op = 4'd5;  end
    else              win_any = 1'b0;
  end

  assign hs = (state_q == ST_REQ) && bus.intr_rdy;

  // A fresh pulse on the granted bit in the handshake cycle re-sets it.
  always_comb begin
    clr_mask = '0;
    if (hs) clr_mask[gnt_q] = 1'b1;
    pend_d = (pend_q & ~clr_mask) | pulse;
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (win_any) begin
          state_d = ST_REQ;
          gnt_d   = win_idx;
          op_d    = win_op;
        end
      end
      ST_REQ:      if (hs) state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: if (bus.intr_clr || timeout) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

`ifdef TOY_INTR_SCHED_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter sits at 0 outside WAIT_CLR, so it starts from 0 on every entry.
  assign cnt_d   = (state_q == ST_WAIT_CLR) ? cnt_q + 1'b1 : '0;
  assign timeout = (state_q == ST_WAIT_CLR) && (cnt_q == CW'(TIMEOUT_CYCLES - 1)) && !bus.intr_clr;

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout            = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      gnt_q   <= 3'd0;
      op_q    <= 4'd0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
    end
  end

  assign bus.intr_vld     = (state_q == ST_REQ);
  assign bus.intr_op      = (state_q == ST_REQ) ? op_q : 4'd0;
  assign bus.intr_pending = pend_q;
  assign bus.intr_busy    = (state_q != ST_IDLE);
  assign bus.intr_timeout = timeout;

endmodule

// File: tb/tb_toy_intr_sched.sv
// tb/tb_toy_intr_sched.sv - directed and randomized checks of toy_intr_sched against a behavioural model
// Define TOY_INTR_SCHED_TIMEOUT_EN to exercise the watchdog with TIMEOUT_CYCLES=8.
module tb_toy_intr_sched;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] pulse = '0;
  logic [5:0] src_en = 6'h3F;
  logic       m_glb_en = 1'b1;
  logic       s_glb_en = 1'b1;
  int         n_cmp = 0;
  int         n_err = 0;

  toy_intr_sched_if #(.NSRC(7)) bus ();

  toy_intr_sched #(.NSRC(7), .TIMEOUT_CYCLES(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .intr_debug_sync (pulse[6]),
    .intr_meip_sync  (pulse[5]),
    .intr_msip_sync  (pulse[4]),
    .intr_mtip_sync  (pulse[3]),
    .intr_seip_sync  (pulse[2]),
    .intr_ssip_sync  (pulse[1]),
    .intr_stip_sync  (pulse[0]),
    .src_en          (src_en),
    .m_glb_en        (m_glb_en),
    .s_glb_en        (s_glb_en),
    .bus             (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL global_time_limit expired");
    $fatal(1);
  end

  function automatic int code_of(int i);
    case (i)
      6: return 15; 5: return 11; 4: return 3; 3: return 7;
      2: return 9;  1: return 1;  default: return 5;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    pulse = '0; src_en = 6'h3F; m_glb_en = 1'b1; s_glb_en = 1'b1;
    bus.intr_rdy = 1'b0; bus.intr_clr = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (bus.intr_vld !== 1'b0) begin n_err++; $display("FAIL reset_vld got %0b want 0", bus.intr_vld); end
    n_cmp++; if (bus.intr_op !== 4'd0) begin n_err++; $display("FAIL reset_op got %0d want 0", bus.intr_op); end
    n_cmp++; if (bus.intr_pending !== 7'd0) begin n_err++; $display("FAIL reset_pending got %h want 0", bus.intr_pending); end
    n_cmp++; if (bus.intr_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %0b want 0", bus.intr_busy); end
    n_cmp++; if (bus.intr_timeout !== 1'b0) begin n_err++; $display("FAIL reset_timeout got %0b want 0", bus.intr_timeout); end
  endtask

  task automatic test_single_mei();
    do_reset();
    bus.intr_rdy = 1'b1;
    pulse[5] = 1'b1;
    step();
    pulse = '0;
    n_cmp++; if (bus.intr_pending[5] !== 1'b1) begin n_err++; $display("FAIL mei_pending_set got %0b want 1", bus.intr_pending[5]); end
    n_cmp++; if (bus.intr_vld !== 1'b0) begin n_err++; $display("FAIL mei_vld_early got %0b want 0", bus.intr_vld); end
    step();
    n_cmp++; if (bus.intr_vld !== 1'b1) begin n_err++; $display("FAIL mei_vld got %0b want 1", bus.intr_vld); end
    n_cmp++; if (bus.intr_op !== 4'd11) begin n_err++; $display("FAIL mei_op got %0d want 11", bus.intr_op); end
    step();
    bus.intr_rdy = 1'b0;
    n_cmp++; if (bus.intr_pending[5] !== 1'b0) begin n_err++; $display("FAIL mei_pending_clr got %0b want 0", bus.intr_pending[5]); end
    n_cmp++; if (bus.intr_vld !== 1'b0) begin n_err++; $display("FAIL mei_vld_after_hs got %0b want 0", bus.intr_vld); end
    n_cmp++; if (bus.intr_busy !== 1'b1) begin n_err++; $display("FAIL mei_busy_wait got %0b want 1", bus.intr_busy); end
    step();
    step();
    bus.intr_clr = 1'b1;
    step();
    bus.intr_clr = 1'b0;
    n_cmp++; if (bus.intr_busy !== 1'b0) begin n_err++; $display("FAIL mei_idle_after_clr got busy %0b want 0", bus.intr_busy); end
  endtask

  task automatic test_simultaneous();
    int exp_op[3] = '{15, 7, 1};
    do_reset();
    bus.intr_rdy = 1'b1;
    pulse = 7'b1001010;
    step();
    pulse = '0;
    step();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.intr_vld !== 1'b1) begin n_err++; $display("FAIL simul_vld[%0d] got %0b want 1", i, bus.intr_vld); end
      n_cmp++; if (bus.intr_op !== exp_op[i][3:0]) begin n_err++; $display("FAIL simul_op[%0d] got %0d want %0d", i, bus.intr_op, exp_op[i]); end
      step();
      bus.intr_clr = 1'b1;
      step();
      bus.intr_clr = 1'b0;
      n_cmp++; if (bus.intr_busy !== 1'b0 || bus.intr_vld !== 1'b0) begin
        n_err++; $display("FAIL simul_idle_gap[%0d] got busy %0b vld %0b want 0 0", i, bus.intr_busy, bus.intr_vld);
      end
      step();
    end
    n_cmp++; if (bus.intr_pending !== 7'd0) begin n_err++; $display("FAIL simul_pending_end got %h want 0", bus.intr_pending); end
  endtask

  task automatic test_masking();
    bit seen_vld = 1'b0;
    do_reset();
    s_glb_en = 1'b0;
    pulse[2] = 1'b1;
    step();
    pulse = '0;
    for (int k = 0; k < 5; k++) begin
      if (bus.intr_vld !== 1'b0) seen_vld = 1'b1;
      step();
    end
    n_cmp++; if (seen_vld !== 1'b0) begin n_err++; $display("FAIL mask_no_vld got vld seen %0b want 0", seen_vld); end
    n_cmp++; if (bus.intr_pending[2] !== 1'b1) begin n_err++; $display("FAIL mask_pending_held got %0b want 1", bus.intr_pending[2]); end
    s_glb_en = 1'b1;
    step();
    step();
    n_cmp++; if (bus.intr_vld !== 1'b1) begin n_err++; $display("FAIL mask_vld_after_en got %0b want 1", bus.intr_vld); end
    n_cmp++; if (bus.intr_op !== 4'd9) begin n_err++; $display("FAIL mask_op got %0d want 9", bus.intr_op); end
  endtask

  task automatic test_stability();
    do_reset();
    pulse[4] = 1'b1;
    step();
    pulse = '0;
    step();
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (bus.intr_vld !== 1'b1 || bus.intr_op !== 4'd3) begin
        n_err++; $display("FAIL hold_op[%0d] got vld %0b op %0d want 1 3", k, bus.intr_vld, bus.intr_op);
      end
      pulse[5] = (k == 2);
      step();
    end
    pulse = '0;
    n_cmp++; if (bus.intr_op !== 4'd3) begin n_err++; $display("FAIL hold_op_final got %0d want 3", bus.intr_op); end
    bus.intr_rdy = 1'b1;
    step();
    bus.intr_rdy = 1'b0;
    n_cmp++; if (bus.intr_pending[5:4] !== 2'b10) begin n_err++; $display("FAIL hold_pending got %b want 10", bus.intr_pending[5:4]); end
    bus.intr_clr = 1'b1;
    step();
    bus.intr_clr = 1'b0;
    step();
    n_cmp++; if (bus.intr_vld !== 1'b1 || bus.intr_op !== 4'd11) begin
      n_err++; $display("FAIL hold_next_grant got vld %0b op %0d want 1 11", bus.intr_vld, bus.intr_op);
    end
  endtask

  task automatic test_collision();
    do_reset();
    pulse[3] = 1'b1;
    step();
    pulse = '0;
    step();
    n_cmp++; if (bus.intr_op !== 4'd7) begin n_err++; $display("FAIL coll_first_op got %0d want 7", bus.intr_op); end
    bus.intr_rdy = 1'b1;
    pulse[3] = 1'b1;
    step();
    bus.intr_rdy = 1'b0;
    pulse = '0;
    n_cmp++; if (bus.intr_pending[3] !== 1'b1) begin n_err++; $display("FAIL coll_pending_kept got %0b want 1", bus.intr_pending[3]); end
    n_cmp++; if (bus.intr_vld !== 1'b0 || bus.intr_busy !== 1'b1) begin
      n_err++; $display("FAIL coll_wait got vld %0b busy %0b want 0 1", bus.intr_vld, bus.intr_busy);
    end
    bus.intr_clr = 1'b1;
    step();
    bus.intr_clr = 1'b0;
    step();
    n_cmp++; if (bus.intr_vld !== 1'b1 || bus.intr_op !== 4'd7) begin
      n_err++; $display("FAIL coll_second_grant got vld %0b op %0d want 1 7", bus.intr_vld, bus.intr_op);
    end
    bus.intr_rdy = 1'b1;
    step();
    bus.intr_rdy = 1'b0;
    n_cmp++; if (bus.intr_pending[3] !== 1'b0) begin n_err++; $display("FAIL coll_pending_final got %0b want 0", bus.intr_pending[3]); end
  endtask

  task automatic test_rst_in_req();
    do_reset();
    pulse = 7'h7F;
    step();
    pulse = '0;
    step();
    n_cmp++; if (bus.intr_vld !== 1'b1) begin n_err++; $display("FAIL rstreq_pre_vld got %0b want 1", bus.intr_vld); end
    rst = 1'b1; pulse = 7'h7F; bus.intr_rdy = 1'b1; bus.intr_clr = 1'b1;
    step();
    n_cmp++; if (bus.intr_vld !== 1'b0) begin n_err++; $display("FAIL rstreq_vld got %0b want 0", bus.intr_vld); end
    n_cmp++; if (bus.intr_pending !== 7'd0) begin n_err++; $display("FAIL rstreq_pending got %h want 0", bus.intr_pending); end
    n_cmp++; if (bus.intr_busy !== 1'b0) begin n_err++; $display("FAIL rstreq_busy got %0b want 0", bus.intr_busy); end
    rst = 1'b0; pulse = '0; bus.intr_rdy = 1'b0; bus.intr_clr = 1'b0;
  endtask

  task automatic test_timeout();
    do_reset();
    bus.intr_rdy = 1'b1;
    pulse[0] = 1'b1;
    step();
    pulse = '0;
    step();
    step();
    bus.intr_rdy = 1'b0;
`ifdef TOY_INTR_SCHED_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      n_cmp++; if (bus.intr_timeout !== 1'b0 || bus.intr_busy !== 1'b1) begin
        n_err++; $display("FAIL to_early[%0d] got timeout %0b busy %0b want 0 1", k, bus.intr_timeout, bus.intr_busy);
      end
      step();
    end
    n_cmp++; if (bus.intr_timeout !== 1'b1) begin n_err++; $display("FAIL to_pulse got %0b want 1", bus.intr_timeout); end
    step();
    n_cmp++; if (bus.intr_timeout !== 1'b0 || bus.intr_busy !== 1'b0) begin
      n_err++; $display("FAIL to_after got timeout %0b busy %0b want 0 0", bus.intr_timeout, bus.intr_busy);
    end
    pulse[0] = 1'b1; bus.intr_rdy = 1'b1;
    step();
    pulse = '0;
    step();
    step();
    bus.intr_rdy = 1'b0;
    repeat (7) step();
    bus.intr_clr = 1'b1;
    #1;
    n_cmp++; if (bus.intr_timeout !== 1'b0) begin n_err++; $display("FAIL to_clr_precedence got %0b want 0", bus.intr_timeout); end
    step();
    bus.intr_clr = 1'b0;
    n_cmp++; if (bus.intr_busy !== 1'b0) begin n_err++; $display("FAIL to_clr_idle got busy %0b want 0", bus.intr_busy); end
`else
    for (int k = 0; k < 12; k++) begin
      n_cmp++; if (bus.intr_timeout !== 1'b0 || bus.intr_busy !== 1'b1) begin
        n_err++; $display("FAIL wait_hold[%0d] got timeout %0b busy %0b want 0 1", k, bus.intr_timeout, bus.intr_busy);
      end
      step();
    end
    bus.intr_clr = 1'b1;
    step();
    bus.intr_clr = 1'b0;
    n_cmp++; if (bus.intr_busy !== 1'b0) begin n_err++; $display("FAIL wait_exit_clr got busy %0b want 0", bus.intr_busy); end
`endif
  endtask

  task automatic test_random(int ncyc);
    bit [6:0] mp = '0;
    bit [6:0] nmp;
    int ph = 0;
    int nph;
    int gi = 0;
    int wait_n = 0;
    bit found;
    logic [3:0] exp_op;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      exp_op = (ph == 1) ? 4'(code_of(gi)) : 4'd0;
      n_cmp++; if (bus.intr_vld !== (ph == 1)) begin n_err++; $display("FAIL rnd_vld c%0d got %0b want %0b", c, bus.intr_vld, ph == 1); end
      n_cmp++; if (bus.intr_op !== exp_op) begin n_err++; $display("FAIL rnd_op c%0d got %0d want %0d", c, bus.intr_op, exp_op); end
      n_cmp++; if (bus.intr_pending !== mp) begin n_err++; $display("FAIL rnd_pending c%0d got %h want %h", c, bus.intr_pending, mp); end
      n_cmp++; if (bus.intr_busy !== (ph != 0)) begin n_err++; $display("FAIL rnd_busy c%0d got %0b want %0b", c, bus.intr_busy, ph != 0); end
      n_cmp++; if (bus.intr_timeout !== 1'b0) begin n_err++; $display("FAIL rnd_timeout c%0d got %0b want 0", c, bus.intr_timeout); end

      for (int i = 0; i < 7; i++) pulse[i] = ($urandom_range(0, 5) == 0);
      src_en       = 6'($urandom);
      m_glb_en     = ($urandom_range(0, 3) != 0);
      s_glb_en     = ($urandom_range(0, 3) != 0);
      bus.intr_rdy = $urandom_range(0, 1) == 1;
      wait_n       = (ph == 2) ? wait_n + 1 : 0;
      bus.intr_clr = (ph == 2 && wait_n >= 4) || ($urandom_range(0, 3) == 0);
      rst          = ($urandom_range(0, 99) == 0);

      if (rst) begin
        mp = '0;
        ph = 0;
      end else begin
        nmp = mp;
        nph = ph;
        if (ph == 1 && bus.intr_rdy) begin
          nmp[gi] = 1'b0;
          nph = 2;
        end
        if (ph == 0) begin
          found = 1'b0;
          for (int i = 6; i >= 0; i--) begin
            if (!found && mp[i] && (i == 6 || (src_en[i] && ((i >= 3) ? m_glb_en : s_glb_en)))) begin
              found = 1'b1;
              gi = i;
              nph = 1;
            end
          end
        end
        if (ph == 2 && bus.intr_clr) nph = 0;
        mp = nmp | pulse;
        ph = nph;
      end
      step();
    end
    rst = 1'b0; pulse = '0; bus.intr_rdy = 1'b0; bus.intr_clr = 1'b0;
  endtask

  initial begin
    bus.intr_rdy = 1'b0;
    bus.intr_clr = 1'b0;
    test_reset();
    test_single_mei();
    test_simultaneous();
    test_masking();
    test_stability();
    test_collision();
    test_rst_in_req();
    test_timeout();
    test_random(400);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
